// File: rtl/bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : bus_arbiter
//  Description : Ownership sequencer for a shared wired-OR data bus.
//                Issues registered one-hot grants, inserts a one-cycle
//                all-zero turnaround between owners and force-releases an
//                owner that keeps its lock asserted for MAX_HOLD cycles.
//                Optional build macro BUS_ARB_FIXED_PRIO_EN selects fixed
//                priority (lowest requesting index wins) instead of the
//                default round-robin arbitration.
//  Revision    : 1.0  initial release
// ============================================================================
module bus_arbiter #(
    parameter int N_SRC    = 7,
    parameter int MAX_HOLD = 8,
    localparam int OW      = $clog2(N_SRC),
    localparam int CW      = $clog2(MAX_HOLD + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_SRC-1:0] req,
    input  logic [N_SRC-1:0] lock,
    output logic [N_SRC-1:0] gnt,
    output logic [OW-1:0]    owner,
    output logic             busy,
    output logic             timeout,
    output logic [OW-1:0]    tout_src
);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_own  = 2'd1;
    localparam logic [1:0] c_st_turn = 2'd2;

    localparam logic [N_SRC-1:0] c_one     = {{(N_SRC-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0]    c_max_cnt = CW'(MAX_HOLD);

    logic [1:0]       r_state;
    logic [N_SRC-1:0] r_gnt;
    logic [OW-1:0]    r_owner;
    logic             r_timeout;
    logic [OW-1:0]    r_tout_src;
    logic [CW-1:0]    r_hold_cnt;

    logic             w_any_req;
    logic [OW-1:0]    w_win;
    logic             w_own_lock;
    logic             w_own_req;
    logic             w_at_max;
    logic             w_release;
    logic             w_forced;

`ifndef BUS_ARB_FIXED_PRIO_EN
    // Last-served source; the search starts just above it so it ranks last.
    logic [OW-1:0]    r_rr_ptr;

    // Index reached by stepping k places above base, wrapping at N_SRC.
    function automatic logic [OW-1:0] f_rr_idx(input logic [OW-1:0] base, input int k);
        int t;
        t = int'(base) + k;
        if (t >= N_SRC) begin
            t = t - N_SRC;
        end
        return OW'(t);
    endfunction
`endif

    // Winner selection: scanning from lowest to highest priority lets the
    // last match (the highest-priority requester) overwrite earlier ones.
    always_comb begin
        w_any_req = |req;
        w_win     = '0;
`ifdef BUS_ARB_FIXED_PRIO_EN
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (req[i]) begin
                w_win = OW'(i);
            end
        end
`else
        for (int k = N_SRC; k >= 1; k--) begin
            if (req[f_rr_idx(r_rr_ptr, k)]) begin
                w_win = f_rr_idx(r_rr_ptr, k);
            end
        end
`endif
    end

    // Release decision for the current owner; a release caused by lock or
    // req dropping takes precedence over the hold-limit, so no timeout.
    always_comb begin
        w_own_lock = lock[r_owner];
        w_own_req  = req[r_owner];
        w_at_max   = (r_hold_cnt == c_max_cnt);
        w_release  = !w_own_lock || !w_own_req || w_at_max;
        w_forced   = w_own_lock && w_own_req && w_at_max;
    end

    // Ownership state machine with registered grant and timeout outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= c_st_idle;
            r_gnt      <= '0;
            r_owner    <= '0;
            r_timeout  <= 1'b0;
            r_tout_src <= '0;
            r_hold_cnt <= '0;
`ifndef BUS_ARB_FIXED_PRIO_EN
            r_rr_ptr   <= OW'(N_SRC - 1);
`endif
        end else begin
            r_timeout <= 1'b0;
            case (r_state)
                c_st_idle, c_st_turn: begin
                    if (w_any_req) begin
                        r_state    <= c_st_own;
                        r_gnt      <= c_one << w_win;
                        r_owner    <= w_win;
                        r_hold_cnt <= CW'(1);
`ifndef BUS_ARB_FIXED_PRIO_EN
                        r_rr_ptr   <= w_win;
`endif
                    end else begin
                        r_state <= c_st_idle;
                        r_gnt   <= '0;
                    end
                end
                c_st_own: begin
                    if (w_release) begin
                        r_state   <= c_st_turn;
                        r_gnt     <= '0;
                        r_timeout <= w_forced;
                        if (w_forced) begin
                            r_tout_src <= r_owner;
                        end
                    end else begin
                        r_hold_cnt <= r_hold_cnt + CW'(1);
                    end
                end
                default: begin
                    r_state <= c_st_idle;
                    r_gnt   <= '0;
                end
            endcase
        end
    end

    assign gnt      = r_gnt;
    assign owner    = r_owner;
    assign busy     = (r_state == c_st_own);
    assign timeout  = r_timeout;
    assign tout_src = r_tout_src;

endmodule
`default_nettype wire
